// File: rtl/mem_reader_pkg.sv
// mem_reader_pkg
//   Shared definitions for the memory read-side initiator:
//   - RV32I load funct3 encodings
//   - FSM state encoding (also exported on the debug state port)
//   - small helpers that classify a load request
package mem_reader_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    // True for the five load encodings RV32I defines.
    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True when the access is not naturally aligned for its size.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_LH, F3_LHU: bad = off[0];
            F3_LW:         bad = (off != 2'b00);
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend
//   Combinational lane select and sign/zero extension for RV32I loads.
//   Ports:
//     word    in  32  full little-endian memory word
//     offset  in   2  byte offset of the load inside the word
//     funct3  in   3  load type (LB/LH/LW/LBU/LHU)
//     result  out 32  extended load value (0 for unknown funct3)
module load_extend
    import mem_reader_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase

        half_sel = offset[1] ? word[31:16] : word[15:0];

        result = 32'h0;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LW:   result = word;
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LHU:  result = {16'h0, half_sel};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_reader.sv
// mem_reader
//   Read-side initiator for a synchronous-read memory. Accepts RV32I load
//   requests, issues one word read, and returns the extended result.
//   Bad requests (illegal funct3, out of range, misaligned) are answered
//   with rsp_err=1 / rsp_data=0 and never reach memory.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both 1. The request side is sampled only on that edge. The response
//   side holds rsp_valid/rsp_data/rsp_err stable until it transfers.
//
//   Ports:
//     clk, resetn            clock, asynchronous active-low reset
//     req_valid/req_ready    request handshake
//     req_addr, req_funct3   byte address and load type
//     rsp_valid/rsp_ready    response handshake
//     rsp_data, rsp_err      extended result, error flag
//     mem_addr, mem_access   word-aligned byte address and read strobe
//     mem_rdata              read data, valid the cycle after the strobe
//     dbg_state              current FSM state
module mem_reader
    import mem_reader_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_access,
    input  logic [31:0] mem_rdata,
    output state_t      dbg_state
);

    // 33 bits so that a full 4 GiB memory still compares correctly.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] mem_addr_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic        req_fire;
    logic        req_bad;
    logic [31:0] ext_data;

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign mem_access = (state_q == ACCESS);
    assign mem_addr   = mem_addr_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign dbg_state  = state_q;

    assign req_fire = req_valid & req_ready;

    // Every failing check produces the same response, so the checks are
    // simply OR-ed; their priority only matters for reporting, not here.
    always_comb begin
        req_bad = 1'b0;
        if (!f3_legal(req_funct3)) begin
            req_bad = 1'b1;
        end else if ({1'b0, req_addr} >= ADDR_LIMIT) begin
            req_bad = 1'b1;
        end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
            req_bad = 1'b1;
        end
    end

    load_extend u_load_extend (
        .word   (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (ext_data)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP: begin
                // No bypass back into a new request in the same cycle.
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latches and response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            mem_addr_q <= 32'h0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (req_fire) begin
                off_q <= req_addr[1:0];
                f3_q  <= req_funct3;
                if (req_bad) begin
                    rsp_err_q  <= 1'b1;
                    rsp_data_q <= 32'h0;
                end else begin
                    // mem_addr only moves for accepted reads; it keeps its
                    // last value otherwise.
                    mem_addr_q <= {req_addr[31:2], 2'b00};
                end
            end
            if (state_q == CAPTURE) begin
                rsp_data_q <= ext_data;
                rsp_err_q  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mem_reader.md
# mem_reader

Read-side initiator for the instruction/data memory's synchronous read port. It accepts RV32I load requests from the core over a valid/ready handshake and drives the memory's word address and read strobe. It captures the word returned one clock later and extracts the byte, halfword or word with sign or zero extension. Misaligned, illegal and out-of-range requests are rejected with an error response and never touch memory.

## Interface
- `MEM_WORDS`, default 256: memory depth in 32-bit words; valid byte addresses are 0 to MEM_WORDS*4-1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  load request valid.
- `req_ready`  out  1  block can accept a request.
- `req_addr`  in  32  byte address.
- `req_funct3`  in  3  RV32I load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  32  extended load result.
- `rsp_err`  out  1  request rejected; rsp_data is 0.
- `mem_addr`  out  32  byte address to memory, always word-aligned (bits [1:0] = 0).
- `mem_access`  out  1  read strobe; memory samples it on the rising edge.
- `mem_rdata`  in  32  memory read data, valid the cycle after the edge that sampled mem_access=1; it holds while mem_access is low.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - ACCESS: mem_access=1.
  - CAPTURE: latch and extract mem_rdata.
  - RESP: rsp_valid=1.
- IDLE, request handshake (req_valid & req_ready):
  - Latch addr[1:0] and funct3.
  - Check order: illegal funct3 (011, 110, 111), then out of range (req_addr >= MEM_WORDS*4, compared as unsigned 32-bit), then misaligned (LH/LHU with addr[0]=1, LW with addr[1:0]≠0).
  - Any failure: go to RESP with rsp_err=1 and rsp_data=0. mem_access stays 0.
  - Otherwise: register mem_addr={req_addr[31:2],2'b00} and go to ACCESS.
- ACCESS: go to CAPTURE unconditionally. This is exactly one cycle of mem_access=1.
- CAPTURE: select the byte lane by addr[1:0], little-endian (byte0=[7:0]). Select the halfword by addr[1] (lower half=[15:0]).
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
  - Register the result into rsp_data with rsp_err=0, then go to RESP.
- RESP: hold rsp_valid, rsp_data and rsp_err stable until rsp_ready=1. On rsp_valid & rsp_ready, clear rsp_valid and return to IDLE.
- req_ready is combinational: (state==IDLE). A response handshake does not bypass to accept a new request in the same cycle.
- mem_addr keeps its last value outside ACCESS. mem_access is 0 in every state except ACCESS.
- Reset is asynchronous. It forces:
  - state=IDLE, mem_access=0, mem_addr=0
  - rsp_valid=0, rsp_data=0, rsp_err=0
  - req_ready=1 (follows from state=IDLE)
- Reset mid-transaction aborts it. No response is produced and any in-flight memory read is discarded.

## Timing
- Valid request handshake at edge N:
  - mem_access=1 during cycle N+1.
  - mem_rdata valid during N+2, captured at the end of N+2.
  - rsp_valid=1 from cycle N+3.
- Error request handshake at edge N: rsp_valid=1 from cycle N+1.
- Response consumed at edge M: req_ready=1 from cycle M+1.
- Next handshake is at edge M+1 at the earliest. Minimum issue interval for back-to-back valid loads with rsp_ready tied high is 4 cycles.
- rsp_ready low stalls indefinitely in RESP with all outputs stable. No memory access is issued while stalled.
- req_* inputs are sampled only at the handshake edge and may change freely afterwards.

## Structure
- Shared package `mem_reader_pkg`:
  - funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - 2-bit state encoding: IDLE=0, ACCESS=1, CAPTURE=2, RESP=3.
- Natural sub-module `load_extend`: combinational. Inputs are the 32-bit word, offset[1:0] and funct3; output is the 32-bit result. It is reused later by the store/load pipeline stage.
- Top level holds the FSM, request checks and output registers.

## Test plan
The memory model used in all scenarios is 256 words with a 1-cycle registered read; word 0x10 holds 0x8034F1A2.
- LW 0x10 handshake at edge N:
  - mem_access=1 only in cycle N+1 with mem_addr=0x10.
  - rsp_valid in N+3, rsp_data=0x8034F1A2, rsp_err=0.
- Extension cases, each consumed before the next:
  - LB 0x13 → 0xFFFFFF80
  - LBU 0x12 → 0x00000034
  - LH 0x12 → 0xFFFF8034
  - LHU 0x10 → 0x0000F1A2
  - LB 0x10 → 0xFFFFFFA2
- Error requests, each with rsp_valid one cycle after handshake, rsp_err=1, rsp_data=0, and mem_access never asserted:
  - LW 0x12
  - LH 0x11
  - funct3=011 at 0x10
  - LW 0x400 (MEM_WORDS=256)
- Backpressure on LW 0x10:
  - Hold rsp_ready=0 for 5 cycles: rsp_valid and rsp_data stay stable, req_ready=0, and a req_valid pulse meanwhile is ignored.
  - Raise rsp_ready: req_ready=1 in the following cycle.
- Assert resetn=0 during CAPTURE of LW 0x10:
  - All outputs go to their reset values immediately.
  - After release, no rsp_valid appears.
  - A new LBU 0x13 returns 0x00000080.
- Back-to-back LW 0x10 / LW 0x14 with rsp_ready=1 and req_valid held: the handshakes are exactly 4 cycles apart.
